score_draw_ctrl: RTL and testbench
==================================

Name: score_draw_ctrl

Overview:
- Holds the two-digit decimal game score, 00 to 99, as BCD tens and ones digits.
- Sequences the score graphing unit to redraw both digit glyphs whenever the score or the game-over state changes.
- Upstream inputs: game logic point/clear pulses and the game_over level.
- Downstream: drives the graphing unit's plot, x_in, y_in, score and gameOver inputs; consumes its done pulse.
- The graphing unit's pixel outputs go straight to the VGA adapter; this block never touches pixel data.

Parameters:
- X_BASE, 9'd256: screen x of the tens digit's top-left corner.
- Y_BASE, 8'd0: screen y passed to the graphing unit. The unit adds its own fixed offset.
- DIGIT_PITCH, 9'd32: x distance from the tens glyph to the ones glyph.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- point  in  1  one-cycle pulse: add 1 to the score
- clear  in  1  one-cycle pulse: score to 00 (new game)
- game_over  in  1  level; selects the black glyph set when high
- gu_done  in  1  graphing unit done pulse (one cycle)
- gu_plot  out  1  one-cycle start pulse to the graphing unit
- gu_x  out  9  x origin of the glyph being drawn
- gu_y  out  8  y origin of the glyph being drawn
- gu_score  out  4  digit (0-9) being drawn
- gu_game_over  out  1  game-over flag for the glyph being drawn
- tens  out  4  current tens digit, BCD
- ones  out  4  current ones digit, BCD
- busy  out  1  high while any redraw is in progress

Behaviour:
Reset (resetn=0 at a clk edge):
- tens=0, ones=0, state=IDLE, gu_plot=0, gu_x=X_BASE, gu_y=Y_BASE, gu_score=0, gu_game_over=0, busy=0.
- dirty=1, so "00" is drawn right after reset.
- go_q (registered copy of game_over) = 0.
- Reset mid-draw aborts the sequence immediately; no further gu_plot is issued until after reset.

Score registers, updated on the clk edge:
- clear has priority over point: result is 00.
- point with ones<9: ones+1.
- point with ones=9 and tens<9: ones=0, tens+1.
- point at 99: saturates at 99, no change, and dirty is not set.
- Any actual change of tens or ones sets dirty.
- clear at 00 still sets dirty.
- A game_over edge (game_over != go_q) sets dirty. go_q <= game_over every cycle.
- Score updates continue while a redraw is in progress; tens/ones reflect the new value on the next edge.

FSM (registered outputs, one state per cycle):
- IDLE: busy=0. If dirty: snapshot snap_t=tens, snap_o=ones, snap_g=game_over; clear dirty; go to PLOT_T. A dirty set on the same edge as the snapshot survives (set wins over clear).
- PLOT_T: gu_plot=1, gu_x=X_BASE, gu_y=Y_BASE, gu_score=snap_t, gu_game_over=snap_g, busy=1. Go to WAIT_T next cycle.
- WAIT_T: gu_plot=0; gu_x, gu_y, gu_score and gu_game_over held unchanged. Stay until gu_done=1, then go to PLOT_O.
- PLOT_O: gu_plot=1, gu_x=X_BASE+DIGIT_PITCH (9-bit wrap), gu_score=snap_o, other outputs as in PLOT_T. Go to WAIT_O.
- WAIT_O: hold outputs; on gu_done go to IDLE.

Rules:
- gu_plot is high for exactly one cycle per digit. Never two plots without an intervening gu_done.
- gu_x, gu_y, gu_score and gu_game_over are stable from the PLOT cycle through the gu_done cycle.
- gu_done seen in IDLE, PLOT_T or PLOT_O is ignored.
- Latency: point at edge n updates ones at n. IDLE sees dirty and moves to PLOT_T at n+1; gu_plot is high in the cycle after n+1.
- Events arriving during a redraw coalesce into one further full redraw after WAIT_O, using the latest values.

Test Plan:
- Reset, then model gu_done 5 cycles after each plot -> two plots: x=256 score=0, then x=288 score=0; busy returns to 0; tens=ones=0.
- From 09, point -> tens=1, ones=0 one edge later; plots carry score=1 at x=256, then score=0 at x=288.
- Score forced to 99, point -> stays 99, no gu_plot within 20 cycles. Same cycle as a later point, assert clear -> 00 and redraw of 0,0.
- Three point pulses during WAIT_T of a 3-to-4 redraw -> current redraw completes with snapshot 0,4; exactly one follow-up redraw with 0,7.
- game_over 0->1 while idle at 42 -> redraw 4,2 with gu_game_over=1 on both plots; score unchanged.
- resetn low during WAIT_O -> no plot after reset release except the reset-driven 00 redraw; stray gu_done in IDLE causes no state change.

Source files
------------

// File: rtl/score_draw_ctrl.sv
// Two-digit BCD score keeper that sequences the score graphing unit to redraw
// both digit glyphs whenever the score or the game-over state changes.
module score_draw_ctrl #(
  parameter logic [8:0] X_BASE      = 9'd256,
  parameter logic [7:0] Y_BASE      = 8'd0,
  parameter logic [8:0] DIGIT_PITCH = 9'd32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       point,
  input  logic       clear,
  input  logic       game_over,
  input  logic       gu_done,
  output logic       gu_plot,
  output logic [8:0] gu_x,
  output logic [7:0] gu_y,
  output logic [3:0] gu_score,
  output logic       gu_game_over,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, PLOT_T, WAIT_T, PLOT_O, WAIT_O} state_t;

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic [3:0] snap_t_q, snap_t_d, snap_o_q, snap_o_d;
  logic       snap_g_q, snap_g_d;
  logic       dirty_q, dirty_d, go_q;
  logic       plot_q, plot_d, busy_q, busy_d, ggo_q, ggo_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [3:0] score_q, score_d;
  logic       dirty_set, dirty_clr;

  // Score update: clear wins, point saturates at 99.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clear) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (point) begin
      if (ones_q != 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else if (tens_q != 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end
    end
    dirty_set = clear | (tens_d != tens_q) | (ones_d != ones_q) | (game_over != go_q);
  end

  // Outputs are registered from the next state, so they line up with it.
  always_comb begin
    state_d   = state_q;
    snap_t_d  = snap_t_q;
    snap_o_d  = snap_o_q;
    snap_g_d  = snap_g_q;
    plot_d    = 1'b0;
    busy_d    = busy_q;
    x_d       = x_q;
    y_d       = y_q;
    score_d   = score_q;
    ggo_d     = ggo_q;
    dirty_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (dirty_q) begin
          snap_t_d  = tens_q;
          snap_o_d  = ones_q;
          snap_g_d  = game_over;
          dirty_clr = 1'b1;
          state_d   = PLOT_T;
          plot_d    = 1'b1;
          busy_d    = 1'b1;
          x_d       = X_BASE;
          y_d       = Y_BASE;
          score_d   = tens_q;
          ggo_d     = game_over;
        end
      end
      PLOT_T: state_d = WAIT_T;
      WAIT_T: begin
        if (gu_done) begin
          state_d = PLOT_O;
          plot_d  = 1'b1;
          x_d     = X_BASE + DIGIT_PITCH;
          score_d = snap_o_q;
        end
      end
      PLOT_O: state_d = WAIT_O;
      WAIT_O: begin
        if (gu_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new event on the snapshot edge must survive for the next redraw.
    dirty_d = dirty_set | (dirty_q & ~dirty_clr);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      snap_t_q <= 4'd0;
      snap_o_q <= 4'd0;
      snap_g_q <= 1'b0;
      dirty_q  <= 1'b1;
      go_q     <= 1'b0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      x_q      <= X_BASE;
      y_q      <= Y_BASE;
      score_q  <= 4'd0;
      ggo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      snap_t_q <= snap_t_d;
      snap_o_q <= snap_o_d;
      snap_g_q <= snap_g_d;
      dirty_q  <= dirty_d;
      go_q     <= game_over;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      score_q  <= score_d;
      ggo_q    <= ggo_d;
    end
  end

  assign gu_plot      = plot_q;
  assign gu_x         = x_q;
  assign gu_y         = y_q;
  assign gu_score     = score_q;
  assign gu_game_over = ggo_q;
  assign tens         = tens_q;
  assign ones         = ones_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_score_draw_ctrl.sv
// Directed bench for score_draw_ctrl: integer-score redraw model compared every
// cycle, plus literal checks on the logged glyph plots.
module tb_score_draw_ctrl;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       point = 1'b0, clear = 1'b0, game_over = 1'b0;
  logic       done_auto = 1'b0, done_man = 1'b0;
  wire        gu_done = done_auto | done_man;
  logic       gu_plot, gu_game_over, busy;
  logic [8:0] gu_x;
  logic [7:0] gu_y;
  logic [3:0] gu_score, tens, ones;

  score_draw_ctrl dut (
    .clk(clk), .resetn(resetn), .point(point), .clear(clear),
    .game_over(game_over), .gu_done(gu_done), .gu_plot(gu_plot),
    .gu_x(gu_x), .gu_y(gu_y), .gu_score(gu_score), .gu_game_over(gu_game_over),
    .tens(tens), .ones(ones), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  typedef struct { int x; int s; int g; } plot_t;
  plot_t plog[$];

  // Graphing-unit stand-in: done pulse 5 cycles after each plot.
  int dcnt = 0;
  always @(negedge clk) begin
    done_auto = 1'b0;
    if (!resetn) dcnt = 0;
    else if (gu_plot === 1'b1) dcnt = 5;
    else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) done_auto = 1'b1;
    end
  end

  // Model: integer score, a pending-redraw flag and the redraw phase.
  localparam int P_IDLE = 0, P_PT = 1, P_WT = 2, P_PO = 3, P_WO = 4;
  int m_score, m_phase, m_snap_t, m_snap_o, m_snap_g;
  bit m_go_prev, m_pending, ev;
  int e_x = 256, e_s = 0, e_g = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_score = 0; m_go_prev = 0; m_pending = 1; m_phase = P_IDLE;
      e_x = 256; e_s = 0; e_g = 0;
    end else begin
      ev = clear || (point && m_score < 99) || (game_over != m_go_prev);
      case (m_phase)
        P_IDLE: if (m_pending) begin
          m_snap_t = m_score / 10; m_snap_o = m_score % 10; m_snap_g = game_over;
          m_pending = 0; m_phase = P_PT;
          e_x = 256; e_s = m_snap_t; e_g = m_snap_g;
        end
        P_PT: m_phase = P_WT;
        P_WT: if (gu_done) begin
          m_phase = P_PO; e_x = 288; e_s = m_snap_o;
        end
        P_PO: m_phase = P_WO;
        default: if (gu_done) m_phase = P_IDLE;
      endcase
      if (ev) m_pending = 1;
      if (clear) m_score = 0;
      else if (point && m_score < 99) m_score++;
      m_go_prev = game_over;
    end
  end

  always @(posedge clk) begin
    int et, eo, ep, eb;
    #1;
    et = m_score / 10; eo = m_score % 10;
    ep = (m_phase == P_PT || m_phase == P_PO) ? 1 : 0;
    eb = (m_phase != P_IDLE) ? 1 : 0;
    total++;
    if (tens !== 4'(et) || ones !== 4'(eo) || gu_plot !== 1'(ep) || busy !== 1'(eb) ||
        gu_x !== 9'(e_x) || gu_y !== 8'd0 || gu_score !== 4'(e_s) || gu_game_over !== 1'(e_g)) begin
      bad++;
      $display("FAIL cycle t=%0t got t/o=%0d/%0d plot=%0d busy=%0d x=%0d y=%0d s=%0d g=%0d want %0d/%0d plot=%0d busy=%0d x=%0d y=0 s=%0d g=%0d",
               $time, tens, ones, gu_plot, busy, gu_x, gu_y, gu_score, gu_game_over,
               et, eo, ep, eb, e_x, e_s, e_g);
    end
    if (gu_plot === 1'b1) plog.push_back('{int'(gu_x), int'(gu_score), int'(gu_game_over)});
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_plot(input int i, input int x, input int s, input int g);
    total++;
    if (i >= plog.size()) begin
      bad++;
      $display("FAIL plot%0d missing got %0d plots want >%0d", i, plog.size(), i);
    end else if (plog[i].x != x || plog[i].s != s || plog[i].g != g) begin
      bad++;
      $display("FAIL plot%0d got x=%0d s=%0d g=%0d want x=%0d s=%0d g=%0d",
               i, plog[i].x, plog[i].s, plog[i].g, x, s, g);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic points(input int n);
    repeat (n) begin point = 1'b1; @(negedge clk); end
    point = 1'b0;
  endtask

  initial begin
    // Reset and the automatic "00" redraw
    cyc(3);
    resetn = 1'b1;
    cyc(30);
    chk("rst_nplots", plog.size(), 2);
    chk_plot(0, 256, 0, 0);
    chk_plot(1, 288, 0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tens", tens, 0);

    // 09 -> 10 carry
    points(9);
    cyc(30);
    plog.delete();
    point = 1'b1;
    @(posedge clk); #2;
    chk("carry_tens", tens, 1);
    chk("carry_ones", ones, 0);
    @(negedge clk); point = 1'b0;
    cyc(30);
    chk("carry_nplots", plog.size(), 2);
    chk_plot(0, 256, 1, 0);
    chk_plot(1, 288, 0, 0);

    // Saturation at 99, then clear with point in the same cycle
    points(89);
    cyc(40);
    plog.delete();
    points(1);
    cyc(20);
    chk("sat_nplots", plog.size(), 0);
    chk("sat_tens", tens, 9);
    chk("sat_ones", ones, 9);
    point = 1'b1; clear = 1'b1;
    @(negedge clk); point = 1'b0; clear = 1'b0;
    cyc(30);
    chk("clr_tens", tens, 0);
    chk("clr_nplots", plog.size(), 2);
    chk_plot(0, 256, 0, 0);
    chk_plot(1, 288, 0, 0);

    // Three points during WAIT_T of a 3->4 redraw coalesce into one more redraw
    points(3);
    cyc(30);
    plog.delete();
    points(1);
    cyc(2);
    points(3);
    cyc(40);
    chk("coal_nplots", plog.size(), 4);
    chk_plot(0, 256, 0, 0);
    chk_plot(1, 288, 4, 0);
    chk_plot(2, 256, 0, 0);
    chk_plot(3, 288, 7, 0);

    // game_over edge at 42
    points(35);
    cyc(40);
    plog.delete();
    game_over = 1'b1;
    cyc(30);
    chk("go_nplots", plog.size(), 2);
    chk_plot(0, 256, 4, 1);
    chk_plot(1, 288, 2, 1);
    chk("go_tens", tens, 4);
    chk("go_ones", ones, 2);

    // Reset during WAIT_O, then a stray done in IDLE
    game_over = 1'b0;
    cyc(30);
    plog.delete();
    points(1);
    begin
      int n = 0;
      while (plog.size() < 2 && n < 50) begin @(negedge clk); n++; end
      chk("wo_reach", (plog.size() >= 2) ? 1 : 0, 1);
    end
    cyc(2);
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(30);
    chk("wo_nplots", plog.size(), 4);
    chk_plot(2, 256, 0, 0);
    chk_plot(3, 288, 0, 0);
    done_man = 1'b1;
    @(negedge clk); done_man = 1'b0;
    cyc(20);
    chk("stray_nplots", plog.size(), 4);
    chk("stray_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
